// File: rtl/iob_axis_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : iob_axis_frame_buffer
// Brief    : AXI-Stream framing stage. Accepts a programmed number of words
//            into a first-word-fall-through FIFO, re-emits them with tlast on
//            the final stored word, and pulses done_o once the frame drains.
//            Build option IOB_AXIS_FRAME_BUFFER_DROP_EN: when defined, words
//            arriving at a full FIFO are dropped and counted instead of being
//            back-pressured.
// Revision : 1.0 - initial release
// ============================================================================
module iob_axis_frame_buffer #(
    parameter int DATA_W      = 32,
    parameter int FIFO_ADDR_W = 4,
    parameter int LEN_W       = 32
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cke_i,
    input  logic [LEN_W-1:0]       cfg_len_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic [DATA_W-1:0]      s_tdata_i,
    input  logic                   s_tvalid_i,
    output logic                   s_tready_o,
    output logic [DATA_W-1:0]      m_tdata_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic                   m_tlast_o,
    output logic [FIFO_ADDR_W:0]   level_o,
    output logic [15:0]            drop_cnt_o
);

    localparam int c_depth = 2 ** FIFO_ADDR_W;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fill  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic [FIFO_ADDR_W:0]   c_level_full = {1'b1, {FIFO_ADDR_W{1'b0}}};
    localparam logic [FIFO_ADDR_W:0]   c_level_one  = (FIFO_ADDR_W+1)'(1);
    localparam logic [FIFO_ADDR_W-1:0] c_ptr_one    = FIFO_ADDR_W'(1);
    localparam logic [LEN_W-1:0]       c_len_one    = LEN_W'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [DATA_W-1:0]      r_mem [c_depth];
    logic [FIFO_ADDR_W-1:0] r_wptr;
    logic [FIFO_ADDR_W-1:0] r_rptr;
    logic [FIFO_ADDR_W:0]   r_level;
    logic [LEN_W-1:0]       r_in_rem;
    logic                   r_done;

    logic w_cfg_ready;
    logic w_busy;
    logic w_s_tready;
    logic w_m_tlast;
    logic w_m_tvalid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_consume;
    logic w_cfg_acc;
    logic w_last_pop;

    // FIFO handshake and frame-progress qualifiers
    assign w_m_tvalid = (r_level != '0);
    assign w_full     = (r_level == c_level_full);
    assign w_pop      = w_m_tvalid & m_tready_i;
    assign w_cfg_acc  = (r_state == c_st_idle) & cfg_valid_i;
    assign w_last_pop = w_pop & (r_state == c_st_drain) & (r_level == c_level_one);
`ifdef IOB_AXIS_FRAME_BUFFER_DROP_EN
    // A full FIFO still takes the word when a pop frees a slot the same cycle
    assign w_drop     = s_tvalid_i & (r_state == c_st_fill) & w_full & ~w_pop;
`else
    assign w_drop     = 1'b0;
`endif
    assign w_push     = s_tvalid_i & w_s_tready & ~w_drop;
    assign w_consume  = w_push | w_drop;

    // FSM state register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= c_st_idle;
        end else if (cke_i) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: frame armed, input counted down, FIFO drained
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_cfg_acc && (cfg_len_i != '0)) begin
                    w_state_nxt = c_st_fill;
                end
            end
            c_st_fill: begin
                if (w_consume && (r_in_rem == c_len_one)) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_last_pop) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // FSM outputs: config handshake, busy, upstream ready and tlast marking
    always_comb begin
        w_cfg_ready = (r_state == c_st_idle);
        w_busy      = (r_state != c_st_idle);
`ifdef IOB_AXIS_FRAME_BUFFER_DROP_EN
        w_s_tready  = (r_state == c_st_fill);
`else
        w_s_tready  = (r_state == c_st_fill) & ~w_full;
`endif
        w_m_tlast   = w_m_tvalid & (r_state == c_st_drain) & (r_level == c_level_one);
    end

    // FIFO pointers, occupancy, remaining-input counter and done pulse
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_in_rem <= '0;
            r_done   <= 1'b0;
        end else if (cke_i) begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_level_one;
                2'b01:   r_level <= r_level - c_level_one;
                default: r_level <= r_level;
            endcase
            if (w_cfg_acc) begin
                r_in_rem <= cfg_len_i;
            end else if ((r_state == c_st_fill) && w_consume) begin
                r_in_rem <= r_in_rem - c_len_one;
            end
            r_done <= (w_cfg_acc && (cfg_len_i == '0)) || w_last_pop;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (cke_i && w_push) begin
            r_mem[r_wptr] <= s_tdata_i;
        end
    end

`ifdef IOB_AXIS_FRAME_BUFFER_DROP_EN
    logic [15:0] r_drop_cnt;

    // Saturating dropped-word counter, cleared when a new frame is armed
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_drop_cnt <= '0;
        end else if (cke_i) begin
            if (w_cfg_acc) begin
                r_drop_cnt <= '0;
            end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = 16'd0;
`endif

    assign cfg_ready_o = w_cfg_ready;
    assign busy_o      = w_busy;
    assign done_o      = r_done;
    assign s_tready_o  = w_s_tready;
    assign m_tdata_o   = r_mem[r_rptr];
    assign m_tvalid_o  = w_m_tvalid;
    assign m_tlast_o   = w_m_tlast;
    assign level_o     = r_level;

endmodule
`default_nettype wire
